// File: rtl/jlut_prog_if.sv
// Lookup-table bus: table write port plus request/response handshake.
interface jlut_prog_if #(
    parameter int PTR_W  = 8,
    parameter int ADDR_W = 8
);
    logic              wr_en;
    logic [PTR_W-1:0]  wr_ptr;
    logic              wr_rel;
    logic [ADDR_W-1:0] wr_data;

    logic              req_valid;
    logic              req_ready;
    logic [PTR_W-1:0]  req_ptr;
    logic [ADDR_W-1:0] req_pc;

    logic              resp_valid;
    logic              resp_ready;
    logic [ADDR_W-1:0] resp_jump;
    logic              resp_miss;

    modport master (
        output wr_en, wr_ptr, wr_rel, wr_data,
        output req_valid, req_ptr, req_pc, resp_ready,
        input  req_ready, resp_valid, resp_jump, resp_miss
    );

    modport slave (
        input  wr_en, wr_ptr, wr_rel, wr_data,
        input  req_valid, req_ptr, req_pc, resp_ready,
        output req_ready, resp_valid, resp_jump, resp_miss
    );
endinterface

// File: rtl/jlut_prog.sv
// Programmable jump-target lookup table. Each entry holds an absolute target
// or a signed PC-relative offset; lookups return a registered response
// through a single-entry output stage.
module jlut_prog #(
    parameter int PTR_W  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 8
) (
    input logic         clk,
    input logic         rst_n,
    jlut_prog_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**PTR_W is representable in the range compare.
    localparam logic [PTR_W:0] DEPTH_X = (PTR_W + 1)'(DEPTH);

    logic              rel_q  [DEPTH];
    logic [ADDR_W-1:0] data_q [DEPTH];

    logic              wr_hit;
    logic              req_hit;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  req_idx;
    logic              collide;
    logic              sel_rel;
    logic [ADDR_W-1:0] sel_data;
    logic [ADDR_W-1:0] jump_d;
    logic              accept;

    logic              resp_valid_q;
    logic [ADDR_W-1:0] resp_jump_q;
    logic              resp_miss_q;

    assign wr_hit  = ({1'b0, bus.wr_ptr}  < DEPTH_X);
    assign req_hit = ({1'b0, bus.req_ptr} < DEPTH_X);
    assign wr_idx  = bus.wr_ptr[IDX_W-1:0];
    assign req_idx = bus.req_ptr[IDX_W-1:0];

    assign bus.req_ready = !resp_valid_q || bus.resp_ready;
    assign accept        = bus.req_valid && bus.req_ready;

    // Resolve the lookup, letting a same-cycle write to the same entry win.
    always_comb begin
        collide  = bus.wr_en && wr_hit && (bus.wr_ptr == bus.req_ptr);
        sel_rel  = 1'b0;
        sel_data = '0;
        jump_d   = '0;
        if (req_hit) begin
            sel_rel  = collide ? bus.wr_rel  : rel_q[req_idx];
            sel_data = collide ? bus.wr_data : data_q[req_idx];
            // Signed offset add is plain modular addition in two's complement.
            jump_d   = sel_rel ? (bus.req_pc + sel_data) : sel_data;
        end
    end

    // Table storage; out-of-range writes are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rel_q[i]  <= 1'b0;
                data_q[i] <= '0;
            end
        end else if (bus.wr_en && wr_hit) begin
            rel_q[wr_idx]  <= bus.wr_rel;
            data_q[wr_idx] <= bus.wr_data;
        end
    end

    // Output stage: load on accept, clear when drained with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_jump_q  <= '0;
            resp_miss_q  <= 1'b0;
        end else if (accept) begin
            resp_valid_q <= 1'b1;
            resp_jump_q  <= jump_d;
            resp_miss_q  <= !req_hit;
        end else if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_jump  = resp_jump_q;
    assign bus.resp_miss  = resp_miss_q;
endmodule

// File: tb/tb_jlut_prog.sv
// Scoreboard bench for jlut_prog: driver pushes expected responses on accept,
// an independent monitor compares whatever the DUT presents.
module tb_jlut_prog;
    localparam int PTR_W  = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 8;

    typedef struct {
        logic [7:0] jump;
        logic       miss;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    int   m_rel  [DEPTH];
    int   m_data [DEPTH];

    jlut_prog_if #(.PTR_W(PTR_W), .ADDR_W(ADDR_W)) bus ();

    jlut_prog #(.PTR_W(PTR_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_rel[i]  = 0;
            m_data[i] = 0;
        end
    endtask

    function automatic exp_t model_lookup(input int ptr, input int pc);
        exp_t e;
        int   off;
        e.miss = 1'b0;
        e.jump = 8'h00;
        if (ptr >= DEPTH) begin
            e.miss = 1'b1;
        end else if (m_rel[ptr] != 0) begin
            off    = (m_data[ptr] >= 128) ? m_data[ptr] - 256 : m_data[ptr];
            e.jump = 8'((pc + off + 256) % 256);
        end else begin
            e.jump = 8'(m_data[ptr]);
        end
        return e;
    endfunction

    // One clock of stimulus; directed calls supply the expected response.
    task automatic drive(input int we, input int wp, input int wrl, input int wd,
                         input int rv, input int rp, input int pc, input int rr,
                         input int use_exp = 0, input int ej = 0, input int em = 0);
        exp_t e;
        @(negedge clk);
        bus.wr_en      = we[0];
        bus.wr_ptr     = 8'(wp);
        bus.wr_rel     = wrl[0];
        bus.wr_data    = 8'(wd);
        bus.req_valid  = rv[0];
        bus.req_ptr    = 8'(rp);
        bus.req_pc     = 8'(pc);
        bus.resp_ready = rr[0];
        #4;
        if (we != 0 && wp < DEPTH) begin
            m_rel[wp]  = wrl;
            m_data[wp] = wd;
        end
        if (rv != 0 && bus.req_ready) begin
            if (use_exp != 0) begin
                e.jump = 8'(ej);
                e.miss = em[0];
            end else begin
                e = model_lookup(rp, pc);
            end
            sb.push_back(e);
        end else if (use_exp != 0) begin
            chk("directed_accept", 0, 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Monitor: response presence, content, stability and ready rule.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                chk("resp_valid", int'(bus.resp_valid), int'(sb.size() != 0));
                chk("req_ready", int'(bus.req_ready),
                    int'(sb.size() == 0 || bus.resp_ready));
                if (bus.resp_valid && sb.size() != 0) begin
                    chk("resp_jump", int'(bus.resp_jump), int'(sb[0].jump));
                    chk("resp_miss", int'(bus.resp_miss), int'(sb[0].miss));
                    if (bus.resp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        bus.wr_en = 0; bus.wr_ptr = 0; bus.wr_rel = 0; bus.wr_data = 0;
        bus.req_valid = 0; bus.req_ptr = 0; bus.req_pc = 0; bus.resp_ready = 1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", int'(bus.resp_valid), 0);
        chk("rst_resp_jump", int'(bus.resp_jump), 0);
        chk("rst_resp_miss", int'(bus.resp_miss), 0);
        chk("rst_req_ready", int'(bus.req_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Empty table reads zero.
        drive(0, 0, 0, 0, 1, 0, 8'h33, 1, 1, 8'h00, 0);
        drive(0, 0, 0, 0, 1, 1, 8'h44, 1, 1, 8'h00, 0);
        idle(2);

        // Absolute and relative entries, including wrap.
        drive(1, 3, 0, 8'hA5, 0, 0, 0, 1);
        drive(1, 4, 1, 8'hFE, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 3, 8'h10, 1, 1, 8'hA5, 0);
        drive(0, 0, 0, 0, 1, 4, 8'h10, 1, 1, 8'h0E, 0);
        drive(0, 0, 0, 0, 1, 4, 8'h01, 1, 1, 8'hFF, 0);
        idle(2);

        // Back-to-back at full throughput.
        drive(0, 0, 0, 0, 1, 3, 8'h00, 1, 1, 8'hA5, 0);
        drive(0, 0, 0, 0, 1, 4, 8'h20, 1, 1, 8'h1E, 0);
        drive(0, 0, 0, 0, 1, 3, 8'h00, 1, 1, 8'hA5, 0);
        idle(2);

        // Stall: response held, rewrite of its entry must not disturb it.
        drive(0, 0, 0, 0, 1, 3, 8'h10, 0, 1, 8'hA5, 0);
        drive(1, 3, 0, 8'h11, 1, 4, 8'h10, 0);
        drive(0, 0, 0, 0, 1, 4, 8'h10, 0);
        drive(0, 0, 0, 0, 1, 4, 8'h10, 0);
        drive(0, 0, 0, 0, 1, 4, 8'h10, 1, 1, 8'h0E, 0);
        drive(0, 0, 0, 0, 1, 3, 8'h10, 1, 1, 8'h11, 0);
        idle(2);

        // Write-first collision, miss, ignored out-of-range write.
        drive(1, 5, 0, 8'h42, 1, 5, 8'h00, 1, 1, 8'h42, 0);
        drive(0, 0, 0, 0, 1, 16, 8'h10, 1, 1, 8'h00, 1);
        drive(1, 20, 0, 8'h77, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 4, 8'h10, 1, 1, 8'h0E, 0);
        idle(2);

        // Asynchronous reset while a response is held.
        drive(0, 0, 0, 0, 1, 5, 8'h00, 0, 1, 8'h42, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(bus.resp_valid), 0);
        chk("async_rst_jump", int'(bus.resp_jump), 0);
        sb.delete();
        model_clear();
        bus.req_valid = 0; bus.wr_en = 0; bus.resp_ready = 1;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 1, 5, 8'h00, 1, 1, 8'h00, 0);
        drive(0, 0, 0, 0, 1, 4, 8'h10, 1, 1, 8'h00, 0);
        drive(0, 0, 0, 0, 1, 3, 8'h10, 1, 1, 8'h00, 0);
        idle(2);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            drive(int'($urandom_range(0, 9) < 3), int'($urandom_range(0, 19)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 9) < 7), int'($urandom_range(0, 17)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 9) < 7));
        end
        idle(4);
        chk("drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
